// File: rtl/lcd_inst_pkg.sv
// ASCII byte constants shared by the text-emitting blocks.
// Only the characters the motor frame needs are kept here.
package lcd_inst_pkg;

    localparam logic [7:0] _OPEN_BRACE   = 8'h7B;
    localparam logic [7:0] _CLOSE_BRACE  = 8'h7D;
    localparam logic [7:0] _DOUBLE_QUOTE = 8'h22;
    localparam logic [7:0] _T            = 8'h54;
    localparam logic [7:0] _L            = 8'h4C;
    localparam logic [7:0] _R            = 8'h52;
    localparam logic [7:0] _COLON        = 8'h3A;
    localparam logic [7:0] _COMMA        = 8'h2C;
    localparam logic [7:0] _PERIOD       = 8'h2E;
    localparam logic [7:0] _MINUS        = 8'h2D;
    localparam logic [7:0] _NEWLINE      = 8'h0A;
    localparam logic [7:0] _0            = 8'h30;
    localparam logic [7:0] _1            = 8'h31;

endpackage

// File: rtl/motor_cmd_pkg.sv
// Shared types and frame geometry for the motor command scheduler.
// Frame: {"T":1,"L":<s>0.<d>,"R":<s>0.<d>}\n
package motor_cmd_pkg;

    import lcd_inst_pkg::*;

    localparam int SPD_W         = 5;
    localparam int FRAME_MIN_LEN = 24;
    localparam int FRAME_MAX_LEN = 26;
    localparam int FRAME_IDX_W   = $clog2(FRAME_MAX_LEN);
    localparam int PREFIX_LEN    = 11;
    localparam int SEC_LEN       = 3;
    localparam int MID_LEN       = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic signed [SPD_W-1:0] l;
        logic signed [SPD_W-1:0] r;
    } wheel_cmd_t;

    typedef logic [FRAME_IDX_W-1:0] fidx_t;

    // Widen by one bit first so the most negative code negates cleanly.
    function automatic logic [3:0] clamp_mag(input logic signed [SPD_W-1:0] v);
        logic signed [SPD_W:0] e;
        e = {v[SPD_W-1], v};
        if (e[SPD_W]) begin
            e = -e;
        end
        return (e > (SPD_W+1)'(9)) ? 4'd9 : e[3:0];
    endfunction

    function automatic logic [7:0] sec_byte(
        input logic       neg,
        input fidx_t      rel,
        input logic [3:0] mag
    );
        fidx_t k;
        k = neg ? rel : rel + fidx_t'(1);
        case (k)
            fidx_t'(0): return _MINUS;
            fidx_t'(1): return _0;
            fidx_t'(2): return _PERIOD;
            default:    return _0 + {4'd0, mag};
        endcase
    endfunction

endpackage

// File: rtl/motor_json_fmt.sv
// Combinational byte generator for one T:1 wheel-speed frame.
// Section positions shift right by one for each negative wheel.
module motor_json_fmt
    import lcd_inst_pkg::*;
    import motor_cmd_pkg::*;
(
    input  wheel_cmd_t  i_cmd,
    input  fidx_t       i_idx,
    output logic [7:0]  o_byte,
    output logic        o_last
);

    logic       w_nl;
    logic       w_nr;
    logic [3:0] w_ml;
    logic [3:0] w_mr;
    fidx_t      w_l_end;
    fidx_t      w_r_start;
    fidx_t      w_r_end;

    function automatic logic [7:0] prefix_byte(input fidx_t k);
        case (k)
            fidx_t'(0): return _OPEN_BRACE;
            fidx_t'(1): return _DOUBLE_QUOTE;
            fidx_t'(2): return _T;
            fidx_t'(3): return _DOUBLE_QUOTE;
            fidx_t'(4): return _COLON;
            fidx_t'(5): return _1;
            fidx_t'(6): return _COMMA;
            fidx_t'(7): return _DOUBLE_QUOTE;
            fidx_t'(8): return _L;
            fidx_t'(9): return _DOUBLE_QUOTE;
            default:    return _COLON;
        endcase
    endfunction

    function automatic logic [7:0] mid_byte(input fidx_t k);
        case (k)
            fidx_t'(0): return _COMMA;
            fidx_t'(1): return _DOUBLE_QUOTE;
            fidx_t'(2): return _R;
            fidx_t'(3): return _DOUBLE_QUOTE;
            default:    return _COLON;
        endcase
    endfunction

    assign w_nl = i_cmd.l[SPD_W-1];
    assign w_nr = i_cmd.r[SPD_W-1];
    assign w_ml = clamp_mag(i_cmd.l);
    assign w_mr = clamp_mag(i_cmd.r);

    assign w_l_end   = fidx_t'(PREFIX_LEN + SEC_LEN) + fidx_t'(w_nl);
    assign w_r_start = w_l_end + fidx_t'(MID_LEN);
    assign w_r_end   = fidx_t'(FRAME_MIN_LEN - 2) + fidx_t'(w_nl) + fidx_t'(w_nr);

    assign o_last = (i_idx == w_r_end + fidx_t'(1));

    always_comb begin
        o_byte = _NEWLINE;
        if (i_idx < fidx_t'(PREFIX_LEN)) begin
            o_byte = prefix_byte(i_idx);
        end else if (i_idx < w_l_end) begin
            o_byte = sec_byte(w_nl, i_idx - fidx_t'(PREFIX_LEN), w_ml);
        end else if (i_idx < w_r_start) begin
            o_byte = mid_byte(i_idx - w_l_end);
        end else if (i_idx < w_r_end) begin
            o_byte = sec_byte(w_nr, i_idx - w_r_start, w_mr);
        end else if (i_idx == w_r_end) begin
            o_byte = _CLOSE_BRACE;
        end
    end

endmodule

// File: rtl/motor_cmd_scheduler.sv
// Fixed-priority wheel command arbiter feeding one UART byte stream.
// Drops repeats of the last frame and re-sends it as a heartbeat.
module motor_cmd_scheduler
    import motor_cmd_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int HEARTBEAT_CYC = 25_000_000,
    parameter int GAP_CYC       = 1_000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*SPD_W-1:0] i_req_l,
    input  logic [N_REQ*SPD_W-1:0] i_req_r,
    output logic [N_REQ-1:0]       o_grant,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy
);

    localparam int HB_W  = $clog2(HEARTBEAT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'(HEARTBEAT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t           r_state;
    state_t           w_next;
    wheel_cmd_t       r_cmd;
    wheel_cmd_t       r_last;
    wheel_cmd_t       w_win_cmd;
    fidx_t            r_idx;
    logic [HB_W-1:0]  r_hb_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [N_REQ-1:0] w_win_oh;
    logic [7:0]       w_byte;
    logic             w_byte_last;
    logic             w_any_req;
    logic             w_hb_exp;
    logic             w_dup;
    logic             w_xfer;
    logic             w_gap_done;
    logic             w_start;

    // Two's-complement trick isolates the lowest set request bit.
    assign w_any_req  = |i_req;
    assign w_win_oh   = i_req & (~i_req + N_REQ'(1));
    assign w_hb_exp   = (r_hb_cnt == HB_LAST);
    assign w_dup      = (w_win_cmd == r_last) && !w_hb_exp;
    assign w_xfer     = (r_state == ST_SEND) && i_tx_ready;
    assign w_gap_done = (r_gap_cnt == GAP_LAST);
    assign w_start    = (r_state == ST_IDLE) && (w_next == ST_SEND);

    always_comb begin
        w_win_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_win_cmd.l = i_req_l[i*SPD_W +: SPD_W];
                w_win_cmd.r = i_req_r[i*SPD_W +: SPD_W];
            end
        end
    end

    motor_json_fmt u_fmt (
        .i_cmd  (r_cmd),
        .i_idx  (r_idx),
        .o_byte (w_byte),
        .o_last (w_byte_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    if (!w_dup) begin
                        w_next = ST_SEND;
                    end
                end else if (w_hb_exp) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_xfer && w_byte_last) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmd     <= '0;
            r_last    <= '0;
            r_idx     <= '0;
            r_hb_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_hb_cnt <= '0;
                        r_idx    <= '0;
                        r_cmd    <= w_any_req ? w_win_cmd : r_last;
                    end else if (!w_hb_exp) begin
                        r_hb_cnt <= r_hb_cnt + HB_W'(1);
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + fidx_t'(1);
                        if (w_byte_last) begin
                            r_last    <= r_cmd;
                            r_gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (!w_gap_done) begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are masked during reset so no byte leaks out of an abandoned frame.
    always_comb begin
        o_grant    = '0;
        o_tx_valid = 1'b0;
        o_tx_data  = '0;
        o_busy     = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_IDLE: o_grant = w_win_oh;
                ST_SEND: begin
                    o_tx_valid = 1'b1;
                    o_tx_data  = w_byte;
                    o_busy     = 1'b1;
                end
                ST_GAP:  o_busy = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
